// File: rtl/regfile_2r1w_if.sv
// Bus bundle for the two-read/one-write register file.
// Read handshake: read_valid_X is high for exactly the one cycle after the edge
// that sampled read_en_X = 1; there is no ready and no backpressure.
interface regfile_2r1w_if #(
  parameter int DATAWIDTH = 8,
  parameter int BITS      = 2
);
  logic                 write_en;
  logic [BITS-1:0]      write_address;
  logic [DATAWIDTH-1:0] write_data;

  logic                 read_en_a;
  logic [BITS-1:0]      read_address_a;
  logic [DATAWIDTH-1:0] read_data_a;
  logic                 read_valid_a;

  logic                 read_en_b;
  logic [BITS-1:0]      read_address_b;
  logic [DATAWIDTH-1:0] read_data_b;
  logic                 read_valid_b;

  modport master (
    output write_en, write_address, write_data,
    output read_en_a, read_address_a,
    output read_en_b, read_address_b,
    input  read_data_a, read_valid_a,
    input  read_data_b, read_valid_b
  );

  modport slave (
    input  write_en, write_address, write_data,
    input  read_en_a, read_address_a,
    input  read_en_b, read_address_b,
    output read_data_a, read_valid_a,
    output read_data_b, read_valid_b
  );
endinterface

// File: rtl/regfile_2r1w.sv
// Register file: 2^BITS entries x DATAWIDTH, one synchronous write port and
// two independent read ports with registered data and a one-cycle valid.
module regfile_2r1w #(
  parameter int DATAWIDTH = 8,
  parameter int BITS      = 2,
  parameter int ZERO_REG  = 0,
  parameter int BYPASS    = 1
) (
  input  logic            clk,
  input  logic            reset,
  regfile_2r1w_if.slave   bus
);

  localparam int DEPTH = 1 << BITS;

  logic [DATAWIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0]     wr_sel;
  logic                 wr_any;
  logic                 hit_a;
  logic                 hit_b;
  logic [DATAWIDTH-1:0] tree_a;
  logic [DATAWIDTH-1:0] tree_b;
  logic [DATAWIDTH-1:0] next_a;
  logic [DATAWIDTH-1:0] next_b;
  logic [DATAWIDTH-1:0] data_a;
  logic [DATAWIDTH-1:0] data_b;
  logic                 valid_a;
  logic                 valid_b;

  // Binary tree of 2:1 selects; address bit l chooses between pairs at level l,
  // so the LSB steers the leaf level. Reduction is done in place from the left.
  function automatic logic [DATAWIDTH-1:0] mux_tree(
    input logic [DATAWIDTH-1:0] ents [DEPTH],
    input logic [BITS-1:0]      addr
  );
    logic [DATAWIDTH-1:0] node [DEPTH];
    for (int i = 0; i < DEPTH; i++) node[i] = ents[i];
    for (int l = 0; l < BITS; l++) begin
      for (int i = 0; i < (DEPTH >> (l + 1)); i++) begin
        node[i] = addr[l] ? node[2*i+1] : node[2*i];
      end
    end
    return node[0];
  endfunction

  // One-hot write decode; entry 0 never enables when it is hardwired to zero.
  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < DEPTH; i++) begin
      wr_sel[i] = bus.write_en && (bus.write_address == i[BITS-1:0]);
    end
    if (ZERO_REG != 0) wr_sel[0] = 1'b0;
  end

  assign wr_any = |wr_sel;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_sel[i]) mem[i] <= bus.write_data;
      end
    end
  end

  // A dropped zero-register write never enables wr_any, so it is never forwarded.
  always_comb begin
    tree_a = mux_tree(mem, bus.read_address_a);
    tree_b = mux_tree(mem, bus.read_address_b);
    hit_a  = (BYPASS != 0) && wr_any && (bus.write_address == bus.read_address_a);
    hit_b  = (BYPASS != 0) && wr_any && (bus.write_address == bus.read_address_b);
    next_a = hit_a ? bus.write_data : tree_a;
    next_b = hit_b ? bus.write_data : tree_b;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_a  <= '0;
      valid_a <= 1'b0;
    end else begin
      valid_a <= bus.read_en_a;
      if (bus.read_en_a) data_a <= next_a;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_b  <= '0;
      valid_b <= 1'b0;
    end else begin
      valid_b <= bus.read_en_b;
      if (bus.read_en_b) data_b <= next_b;
    end
  end

  assign bus.read_data_a  = data_a;
  assign bus.read_valid_a = valid_a;
  assign bus.read_data_b  = data_b;
  assign bus.read_valid_b = valid_b;

endmodule
